pll_sweep_ctrl: RTL
===================

Name: pll_sweep_ctrl

Overview:
- Parametrised successor to the memtest top-level frequency stepper: a reconfiguration sequencer for an Altera-style PLL reconfig core, driven through an Avalon-MM management port.
- Walks an external table of ENTRIES frequency settings, each holding M, K and C0.
- Supports manual step up/down, retune of the current entry, and automatic advance on a test-pass event.
- Keeps a BCD elapsed-minutes counter and a seconds tick that both clear on every retune.

Parameters:
- ENTRIES, 38, number of table entries (≥2).
- IDX_W, 6, index width; must satisfy 2^IDX_W ≥ ENTRIES.
- CLK_HZ, 50000000, clk frequency in Hz.
- BCD_DIGITS, 4, number of minute digits; the counter wraps at all nines.
- GAP_CYC, 7, idle cycles inserted between consecutive management writes.
- RST_CYC, 8, width of the pll_reset pulse in cycles.
- LOCK_TO, 5000000, cycles to wait for lock before flagging an error.

Ports:
- clk  in  1  management/system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_up  in  1  pulse: index+1, then retune.
- cmd_down  in  1  pulse: index-1, then retune.
- cmd_retune  in  1  pulse: retune the current index.
- cmd_auto  in  1  pulse: index←0, auto←1, then retune.
- step_ok  in  1  pulse: test pass, used for auto advance.
- locked  in  1  PLL locked, asynchronous; synchronised internally with 2 flops.
- tbl_idx  out  IDX_W  table address (registered; equals idx).
- tbl_m, tbl_k, tbl_c  in  32 each  table data, valid 1 cycle after tbl_idx changes.
- mgmt_address  out  6  management address.
- mgmt_writedata  out  32  management write data.
- mgmt_write  out  1  management write strobe.
- mgmt_waitrequest  in  1  Avalon waitrequest.
- pll_reset  out  1  PLL reset.
- busy  out  1  sequence in progress.
- auto_mode  out  1  auto-advance enabled.
- lock_err  out  1  sticky lock-timeout error; cleared at the next sequence start.
- minutes  out  4*BCD_DIGITS  BCD elapsed minutes.
- sec_tick  out  1  one-cycle pulse each second.

Behaviour:
Reset values:
- All outputs 0; idx=0; state IDLE.
- No sequence runs after reset until the first command.

Command handling:
- Commands are sampled every cycle. Priority when several are high together: cmd_auto > cmd_retune > cmd_up > cmd_down.
- cmd_up at idx=ENTRIES-1 is ignored entirely (no retune).
- cmd_down at idx=0 is ignored entirely (no retune).
- cmd_up, cmd_down and cmd_retune clear auto_mode.
- An accepted command while busy aborts the sequence:
  - an in-flight write (mgmt_write=1) is held until accepted;
  - pll_reset is deasserted;
  - the sequence restarts at LOAD with the new idx.

Sequencer states:
- IDLE
- LOAD: 1 cycle, waits for table data.
- WR(n), n=0..7
- GAP
- RST
- LOCKWAIT
- busy=1 in every state except IDLE.

Write sequence (address, data):
- n=0: 0, 0
- n=1: 4, M
- n=2: 7, K
- n=3: 3, 0x10000
- n=4: 5, C0
- n=5: 9, 1
- n=6: 8, 7
- n=7: 2, 0

Write handshake and timing:
- mgmt_write, mgmt_address and mgmt_writedata stay stable while mgmt_waitrequest=1.
- The write completes on the first cycle with mgmt_write=1 and mgmt_waitrequest=0.
- Each completed write is followed by GAP_CYC cycles in GAP before the next WR.
- After WR7 and its gap, RST holds pll_reset=1 for exactly RST_CYC cycles.
- LOCKWAIT exits to IDLE on synchronised locked=1.
- If LOCKWAIT reaches LOCK_TO cycles, lock_err←1 and the state goes to IDLE.
- M, K and C0 are captured in LOAD, so table changes mid-sequence have no effect.

Auto advance:
- If step_ok=1, auto_mode=1, !busy and idx<ENTRIES-1: idx+1 and retune.
- At idx=ENTRIES-1, step_ok does nothing and auto_mode stays 1.

Timer:
- While busy, the divider, minutes and sec_tick are held at 0.
- Otherwise a 32-bit divider produces sec_tick every CLK_HZ cycles.
- A seconds counter 0..59 increments minutes on wrap.
- Minutes increment per BCD digit with carry: a digit at 9 becomes 0 and carries; all nines wraps to 0.
- The first sec_tick occurs CLK_HZ cycles after busy falls.

Test Plan:
1. Reset, then cmd_retune with waitrequest=0 and table M=0x808, K=0x...
   → writes (0,0)(4,0x808)(7,K)(3,0x10000)(5,C)(9,1)(8,7)(2,0), each separated by GAP_CYC idle cycles;
   → pll_reset high for exactly 8 cycles;
   → busy falls 3 cycles after locked rises.
2. Hold waitrequest=1 for 5 cycles during WR1
   → mgmt_write, address 4 and data stable for all 6 cycles; then a single accept.
3. idx=37 (ENTRIES=38), cmd_up → no writes, busy stays 0. idx=0, cmd_down → same result.
4. cmd_auto, lock, then step_ok three times, each after busy falls
   → idx 0→1→2→3, each step producing a full 8-write sequence;
   → cmd_up then clears auto_mode.
5. CLK_HZ=10, BCD_DIGITS=2, locked held high
   → sec_tick every 10 cycles;
   → minutes=0x01 after 600 cycles;
   → 0x99 wraps to 0x00;
   → cmd_retune clears minutes to 0.
6. locked tied 0, LOCK_TO=100 → lock_err=1 at LOCKWAIT+100 cycles. Mid-WR3, cmd_down → WR3 completes, then restart at WR0 with idx-1.

Source files
------------

// File: rtl/pll_sweep_ctrl.sv
// PLL frequency-table sweep sequencer: walks M/K/C0 entries and reprograms an
// Altera-style PLL reconfig core over Avalon-MM, with a BCD minutes timer.
module pll_sweep_ctrl #(
    parameter int unsigned ENTRIES    = 38,
    parameter int unsigned IDX_W      = 6,
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BCD_DIGITS = 4,
    parameter int unsigned GAP_CYC    = 7,
    parameter int unsigned RST_CYC    = 8,
    parameter int unsigned LOCK_TO    = 5000000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_up,
    input  logic                    cmd_down,
    input  logic                    cmd_retune,
    input  logic                    cmd_auto,
    input  logic                    step_ok,
    input  logic                    locked,
    output logic [IDX_W-1:0]        tbl_idx,
    input  logic [31:0]             tbl_m,
    input  logic [31:0]             tbl_k,
    input  logic [31:0]             tbl_c,
    output logic [5:0]              mgmt_address,
    output logic [31:0]             mgmt_writedata,
    output logic                    mgmt_write,
    input  logic                    mgmt_waitrequest,
    output logic                    pll_reset,
    output logic                    busy,
    output logic                    auto_mode,
    output logic                    lock_err,
    output logic [4*BCD_DIGITS-1:0] minutes,
    output logic                    sec_tick
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(ENTRIES - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR, S_GAP, S_RST, S_LOCKWAIT} state_t;

    state_t                  state, state_next;
    logic [IDX_W-1:0]        idx, idx_next;
    logic                    auto_q, auto_next, accept, pend;
    logic [2:0]              wr_n;
    logic [31:0]             cnt, m_q, k_q, c_q, div_q;
    logic                    lock_s1, lock_s2, lock_err_q, tick_q;
    logic [5:0]              sec_q;
    logic [4*BCD_DIGITS-1:0] min_q, min_inc;
    logic                    carry;

    always_comb begin
        accept    = 1'b0;
        idx_next  = idx;
        auto_next = auto_q;
        if (cmd_auto) begin
            accept    = 1'b1;
            idx_next  = '0;
            auto_next = 1'b1;
        end else if (cmd_retune) begin
            accept    = 1'b1;
            auto_next = 1'b0;
        end else if (cmd_up) begin
            if (idx != LAST) begin
                accept    = 1'b1;
                idx_next  = idx + 1'b1;
                auto_next = 1'b0;
            end
        end else if (cmd_down) begin
            if (idx != '0) begin
                accept    = 1'b1;
                idx_next  = idx - 1'b1;
                auto_next = 1'b0;
            end
        end else if (step_ok && auto_q && state == S_IDLE && idx != LAST) begin
            accept   = 1'b1;
            idx_next = idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // A restart request waits in pend while a write is stalled by waitrequest.
    always_comb begin
        state_next = state;
        if ((accept || pend) && !(state == S_WR && mgmt_waitrequest)) begin
            state_next = S_LOAD;
        end else begin
            case (state)
                S_IDLE:     state_next = S_IDLE;
                S_LOAD:     state_next = S_WR;
                S_WR:       if (!mgmt_waitrequest) state_next = S_GAP;
                S_GAP:      if (cnt == GAP_CYC - 1) state_next = (wr_n == 3'd7) ? S_RST : S_WR;
                S_RST:      if (cnt == RST_CYC - 1) state_next = S_LOCKWAIT;
                S_LOCKWAIT: if (lock_s2 || cnt == LOCK_TO - 1) state_next = S_IDLE;
                default:    state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy           = (state != S_IDLE);
        pll_reset      = (state == S_RST);
        mgmt_write     = 1'b0;
        mgmt_address   = '0;
        mgmt_writedata = '0;
        if (state == S_WR) begin
            mgmt_write = 1'b1;
            case (wr_n)
                3'd0:    begin mgmt_address = 6'd0; mgmt_writedata = '0;           end
                3'd1:    begin mgmt_address = 6'd4; mgmt_writedata = m_q;          end
                3'd2:    begin mgmt_address = 6'd7; mgmt_writedata = k_q;          end
                3'd3:    begin mgmt_address = 6'd3; mgmt_writedata = 32'h0001_0000; end
                3'd4:    begin mgmt_address = 6'd5; mgmt_writedata = c_q;          end
                3'd5:    begin mgmt_address = 6'd9; mgmt_writedata = 32'd1;        end
                3'd6:    begin mgmt_address = 6'd8; mgmt_writedata = 32'd7;        end
                default: begin mgmt_address = 6'd2; mgmt_writedata = '0;           end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            auto_q     <= 1'b0;
            pend       <= 1'b0;
            cnt        <= '0;
            wr_n       <= '0;
            m_q        <= '0;
            k_q        <= '0;
            c_q        <= '0;
            lock_s1    <= 1'b0;
            lock_s2    <= 1'b0;
            lock_err_q <= 1'b0;
        end else begin
            idx     <= idx_next;
            auto_q  <= auto_next;
            lock_s1 <= locked;
            lock_s2 <= lock_s1;
            if (state_next == S_LOAD) pend <= 1'b0;
            else if (accept)          pend <= 1'b1;
            if (state_next != state || state == S_IDLE) cnt <= '0;
            else                                        cnt <= cnt + 32'd1;
            if (state_next == S_LOAD)                       wr_n <= '0;
            else if (state == S_GAP && state_next == S_WR) wr_n <= wr_n + 3'd1;
            if (state == S_LOAD) begin
                m_q <= tbl_m;
                k_q <= tbl_k;
                c_q <= tbl_c;
            end
            if (state_next == S_LOAD)
                lock_err_q <= 1'b0;
            else if (state == S_LOCKWAIT && !lock_s2 && cnt == LOCK_TO - 1)
                lock_err_q <= 1'b1;
        end
    end

    always_comb begin
        min_inc = min_q;
        carry   = 1'b1;
        for (int unsigned d = 0; d < BCD_DIGITS; d++) begin
            if (carry) begin
                if (min_q[4*d +: 4] == 4'd9) begin
                    min_inc[4*d +: 4] = 4'd0;
                end else begin
                    min_inc[4*d +: 4] = min_q[4*d +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    // The timer restarts from zero whenever a sequence is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            tick_q <= 1'b0;
        end else if (state != S_IDLE) begin
            div_q  <= '0;
            sec_q  <= '0;
            min_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (div_q == CLK_HZ - 1) begin
                div_q  <= '0;
                tick_q <= 1'b1;
                if (sec_q == 6'd59) begin
                    sec_q <= '0;
                    min_q <= min_inc;
                end else begin
                    sec_q <= sec_q + 6'd1;
                end
            end else begin
                div_q <= div_q + 32'd1;
            end
        end
    end

    assign tbl_idx   = idx;
    assign auto_mode = auto_q;
    assign lock_err  = lock_err_q;
    assign minutes   = min_q;
    assign sec_tick  = tick_q;

endmodule
